// File: rtl/id_scoreboard_forward.sv
// -----------------------------------------------------------------------------
// id_scoreboard_forward
//   ID-stage hazard detection and operand forwarding unit. It keeps a shift
//   scoreboard of in-flight register writes across FWD_STAGES downstream
//   stages. Entry e[1] is the EX stage. Each entry holds a valid bit, the
//   destination register and a countdown that reaches zero when the result can
//   be forwarded. A load enters with LOAD_LAT, so a load-use pair stalls
//   until the load data reaches a stage that can forward it.
//
// Parameters
//   NUM_SRC     number of ID source operands checked
//   FWD_STAGES  downstream stages able to forward (1=EX, 2=MEM, ...)
//   LOAD_LAT    extra cycles after EX before load data is forwardable
//   SELW        width of one forward select (derived)
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous reset, active high
//   id_valid        ID holds a real instruction
//   id_src_addr     source register numbers, port i at [5*i +: 5]
//   id_src_used     port i is actually read by the instruction
//   id_dst_addr     destination register of the ID instruction
//   id_dst_we       ID instruction writes a register
//   id_dst_is_load  ID instruction is a load
//   id_flush        squash the ID instruction and insert a bubble
//   fwd_sel         per port: 0 = regfile, k = result of stage k
//   stall           hold PC and IF_ID, bubble into EX (combinational)
//   issue           ID instruction advances this cycle (combinational)
//   stall_count     saturating count of stall cycles (registered)
// -----------------------------------------------------------------------------
module id_scoreboard_forward #(
    parameter int  NUM_SRC    = 2,
    parameter int  FWD_STAGES = 2,
    parameter int  LOAD_LAT   = 1,
    localparam int SELW       = $clog2(FWD_STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [NUM_SRC*5-1:0]    id_src_addr,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic [4:0]              id_dst_addr,
    input  logic                    id_dst_we,
    input  logic                    id_dst_is_load,
    input  logic                    id_flush,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic                    stall,
    output logic                    issue,
    output logic [15:0]             stall_count
);

    // Countdowns never exceed LOAD_LAT < FWD_STAGES, so SELW bits suffice.
    logic            v_r    [1:FWD_STAGES];
    logic [4:0]      addr_r [1:FWD_STAGES];
    logic [SELW-1:0] cnt_r  [1:FWD_STAGES];
    logic [15:0]     stall_count_r;

    logic [NUM_SRC*SELW-1:0] fwd_sel_s;
    logic [NUM_SRC-1:0]      port_stall_s;
    logic                    stall_s;
    logic                    issue_s;
    logic                    alloc_s;

    // Countdown step applied as an entry moves one stage down the pipe.
    function automatic logic [SELW-1:0] sat_dec(input logic [SELW-1:0] c);
        sat_dec = (c == '0) ? '0 : (c - SELW'(1));
    endfunction

    // Per-port scoreboard lookup: scan oldest to youngest so the youngest
    // matching producer overwrites older ones. A younger entry that is not
    // ready yet therefore blocks forwarding from an older ready entry.
    always_comb begin
        fwd_sel_s    = '0;
        port_stall_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [4:0]      src_v;
            logic [SELW-1:0] sel_v;
            logic            req_v;
            logic            hit_v;
            src_v = id_src_addr[5*i +: 5];
            sel_v = '0;
            req_v = 1'b0;
            hit_v = 1'b0;
            for (int k = FWD_STAGES; k >= 1; k--) begin
                hit_v = id_src_used[i] && (src_v != 5'd0) && v_r[k] && (addr_r[k] == src_v);
                sel_v = hit_v ? ((cnt_r[k] == '0) ? SELW'(k) : '0) : sel_v;
                req_v = hit_v ? (cnt_r[k] != '0) : req_v;
            end
            fwd_sel_s[SELW*i +: SELW] = sel_v;
            port_stall_s[i]           = req_v;
        end
    end

    // A flushed instruction never stalls; it is simply replaced by a bubble.
    assign stall_s = id_valid & ~id_flush & (|port_stall_s);
    assign issue_s = id_valid & ~stall_s & ~id_flush;
    assign alloc_s = issue_s & id_dst_we & (id_dst_addr != 5'd0);

    // Scoreboard shift, new-entry allocation and stall cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
                v_r[k]    <= 1'b0;
                addr_r[k] <= 5'd0;
                cnt_r[k]  <= '0;
            end
            stall_count_r <= 16'd0;
        end else begin
            v_r[1]    <= alloc_s;
            addr_r[1] <= alloc_s ? id_dst_addr : 5'd0;
            cnt_r[1]  <= (alloc_s && id_dst_is_load) ? SELW'(LOAD_LAT) : '0;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                v_r[k]    <= v_r[k-1];
                addr_r[k] <= addr_r[k-1];
                cnt_r[k]  <= sat_dec(cnt_r[k-1]);
            end
            if (stall_s && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign fwd_sel     = fwd_sel_s;
    assign stall       = stall_s;
    assign issue       = issue_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_id_scoreboard_forward.sv
// Bench for id_scoreboard_forward. Three instances share the ID inputs:
//   a: FWD_STAGES=2,  LOAD_LAT=1   (default pipeline)
//   b: FWD_STAGES=3,  LOAD_LAT=2   (longer load latency)
//   c: FWD_STAGES=16, LOAD_LAT=15  (dense stalling for counter saturation)
// Expected values are queued when a step is driven and compared on the
// following falling edge, where the combinational outputs are settled.
module tb_id_scoreboard_forward;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst_addr;
    logic        id_dst_we;
    logic        id_dst_is_load;
    logic        id_flush;

    logic [3:0]  a_fwd, b_fwd;
    logic [9:0]  c_fwd;
    logic        a_stall, b_stall, c_stall;
    logic        a_issue, b_issue, c_issue;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    always #5 clk = ~clk;

    id_scoreboard_forward #(.NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_dst_is_load(id_dst_is_load), .id_flush(id_flush),
        .fwd_sel(a_fwd), .stall(a_stall), .issue(a_issue), .stall_count(a_cnt));

    id_scoreboard_forward #(.NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_dst_is_load(id_dst_is_load), .id_flush(id_flush),
        .fwd_sel(b_fwd), .stall(b_stall), .issue(b_issue), .stall_count(b_cnt));

    id_scoreboard_forward #(.NUM_SRC(2), .FWD_STAGES(16), .LOAD_LAT(15)) dut_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_dst_is_load(id_dst_is_load), .id_flush(id_flush),
        .fwd_sel(c_fwd), .stall(c_stall), .issue(c_issue), .stall_count(c_cnt));

    localparam int A_FWD0 = 0, A_FWD1 = 1, A_STALL = 2, A_ISSUE = 3, A_CNT = 4;
    localparam int B_FWD0 = 5, B_STALL = 6, B_CNT = 7;
    localparam int C_FWD0 = 8, C_STALL = 9, C_CNT = 10;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] get_obs(input int sig);
        case (sig)
            A_FWD0:  get_obs = {30'd0, a_fwd[1:0]};
            A_FWD1:  get_obs = {30'd0, a_fwd[3:2]};
            A_STALL: get_obs = {31'd0, a_stall};
            A_ISSUE: get_obs = {31'd0, a_issue};
            A_CNT:   get_obs = {16'd0, a_cnt};
            B_FWD0:  get_obs = {30'd0, b_fwd[1:0]};
            B_STALL: get_obs = {31'd0, b_stall};
            B_CNT:   get_obs = {16'd0, b_cnt};
            C_FWD0:  get_obs = {27'd0, c_fwd[4:0]};
            C_STALL: get_obs = {31'd0, c_stall};
            C_CNT:   get_obs = {16'd0, c_cnt};
            default: get_obs = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = val;
        q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = get_obs(e.sig);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // One clock: compare queued expectations at negedge, then move past posedge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic u0,
                         input logic [4:0] s1, input logic u1, input logic [4:0] dst,
                         input logic we, input logic ld, input logic fl);
        id_valid       = v;
        id_src_addr    = {s1, s0};
        id_src_used    = {u1, u0};
        id_dst_addr    = dst;
        id_dst_we      = we;
        id_dst_is_load = ld;
        id_flush       = fl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_model;
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Reset state: empty scoreboard, nothing forwarded or stalled
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("rst_fwd0", A_FWD0, 32'd0);
        expect_val("rst_fwd1", A_FWD1, 32'd0);
        expect_val("rst_stall", A_STALL, 32'd0);
        expect_val("rst_issue", A_ISSUE, 32'd1);
        expect_val("rst_cnt", A_CNT, 32'd0);
        step();

        // ALU chain: forward from EX, then MEM, then regfile
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        expect_val("alu_issue", A_ISSUE, 32'd1);
        expect_val("alu_stall0", A_STALL, 32'd0);
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("alu_fwd_ex", A_FWD0, 32'd1);
        expect_val("alu_stall1", A_STALL, 32'd0);
        step();
        expect_val("alu_fwd_mem", A_FWD0, 32'd2);
        step();
        expect_val("alu_fwd_rf", A_FWD0, 32'd0);
        step();

        // Load-use with LOAD_LAT=1: one stall, then forward from MEM
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("lu_stall", A_STALL, 32'd1);
        expect_val("lu_noissue", A_ISSUE, 32'd0);
        step();
        expect_val("lu_stall_end", A_STALL, 32'd0);
        expect_val("lu_fwd1", A_FWD1, 32'd2);
        expect_val("lu_issue", A_ISSUE, 32'd1);
        expect_val("lu_cnt", A_CNT, 32'd1);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("lu_cnt_hold", A_CNT, 32'd1);
        step();

        // LOAD_LAT=2, FWD_STAGES=3: two stalls, then forward from stage 3
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("ll2_stall_a", B_STALL, 32'd1);
        step();
        expect_val("ll2_stall_b", B_STALL, 32'd1);
        step();
        expect_val("ll2_stall_end", B_STALL, 32'd0);
        expect_val("ll2_fwd", B_FWD0, 32'd3);
        expect_val("ll2_cnt", B_CNT, 32'd2);
        step();

        // Shadowing: unready younger load hides ready older add
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("shadow_stall", A_STALL, 32'd1);
        step();
        expect_val("shadow_stall_end", A_STALL, 32'd0);
        expect_val("shadow_fwd", A_FWD0, 32'd2);
        step();

        // Register zero never matches; unused port never stalls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("r0_fwd0", A_FWD0, 32'd0);
        expect_val("r0_fwd1", A_FWD1, 32'd0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd6, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("unused_stall", A_STALL, 32'd0);
        expect_val("unused_issue", A_ISSUE, 32'd1);
        expect_val("unused_fwd0", A_FWD0, 32'd0);
        step();

        // Flush over a hazard: no stall, bubble in place of the flushed writer
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
        expect_val("flush_stall", A_STALL, 32'd0);
        expect_val("flush_issue", A_ISSUE, 32'd0);
        step();
        drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("flush_fwd0", A_FWD0, 32'd2);
        expect_val("flush_bubble", A_FWD1, 32'd0);
        expect_val("flush_nostall", A_STALL, 32'd0);
        expect_val("flush_cnt", A_CNT, 32'd0);
        step();

        // Reset in the middle of a two-cycle stall
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        expect_val("rmid_stall", B_STALL, 32'd1);
        step();
        reset = 1'b0;
        expect_val("rmid_after_stall", B_STALL, 32'd0);
        expect_val("rmid_after_fwd", B_FWD0, 32'd0);
        expect_val("rmid_after_cnt", B_CNT, 32'd0);
        step();

        // Saturation: self-dependent load on instance c stalls 15 of every 16 cycles
        do_reset();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        sat_model = 0;
        for (int i = 0; i < 70102; i++) begin
            if (i == 1600) begin
                expect_val("sat_mid_cnt", C_CNT, 32'(sat_model));
                expect_val("sat_mid_stall", C_STALL, 32'd0);
                expect_val("sat_mid_fwd", C_FWD0, 32'd16);
            end
            if (i == 70100) begin
                expect_val("sat_cnt", C_CNT, 32'(sat_model));
                expect_val("sat_stall", C_STALL, 32'd1);
            end
            if (i == 70101) begin
                expect_val("sat_hold", C_CNT, 32'h0000_FFFF);
            end
            step();
            if (((i % 16) != 0) && (sat_model != 65535)) begin
                sat_model++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
